// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side packetizer: default widths, FIFO depth, FSM encoding.
// No logic; imported by the interface, the skid buffer and the top level.
package fifo_pkg;
  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 10;
  localparam int FIFO_DEPTH_DEF = 1 << AWIDTH_DEF;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_XFER_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE = ST_IDLE_ENC,
    ST_XFER = ST_XFER_ENC
  } state_t;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/fifo_rd_axis_packetizer_if.sv
// AXI-Stream bundle between the packetizer (master) and its consumer (slave).
// Pure wiring; tready is the only signal flowing against the data.
interface fifo_rd_axis_packetizer_if import fifo_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF
);
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fifo_rd_axis_packetizer_skid_buf_2.sv
// 2-entry buffer absorbing the BRAM read latency; head is combinational from storage.
// Write and pop in the same cycle keep cnt unchanged; the caller must never write when full without popping.
module skid_buf_2 import fifo_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_dat,
  input  logic              rd_en,
  output logic [1:0]        cnt,
  output logic [DWIDTH-1:0] head,
  output logic              full,
  output logic              empty
);
  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (wr_en) r_wr_ptr <= ~r_wr_ptr;
      if (rd_en) r_rd_ptr <= ~r_rd_ptr;
      case ({wr_en, rd_en})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_dat;
  end

  assign cnt   = r_cnt;
  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_cnt == 2'd2);
  assign empty = (r_cnt == 2'd0);
endmodule

// File: rtl/fifo_rd_axis_packetizer.sv
// FIFO read port to AXI-Stream packetizer, tlast every len_q beats; first beat 2 cycles after first pop, 1 word/cycle.
// Pops stop once buffered+in-flight reaches 2 under tready backpressure; FIFO_RD_PKT_GATE_EN adds whole-packet start gating.
module fifo_rd_axis_packetizer import fifo_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      fifo_rd_en,
  input  logic [DWIDTH-1:0]         fifo_dout,
  input  logic                      fifo_empty,
  input  logic [AWIDTH:0]           fifo_data_count,
  input  logic [LEN_W-1:0]          pkt_len,
  fifo_rd_axis_packetizer_if.master m,
  output logic [CNT_W-1:0]          pkt_count,
  output logic                      busy
);
  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len_q, w_len_nxt;
  logic [LEN_W-1:0]  r_beat, w_beat_nxt;
  logic [CNT_W-1:0]  r_pkt_count;
  logic              w_pkt_inc;
  logic              r_inflight;
  logic [1:0]        w_cnt;
  logic [DWIDTH-1:0] w_head;
  logic              w_unused_full;
  logic              w_empty;
  logic              w_xfer;
  logic              w_rd_en;
  logic              w_pop_allow;
  logic              w_last_beat;
  logic              w_more;
  logic [2:0]        w_occ_nxt;
  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_next_len;

  skid_buf_2 #(.DWIDTH(DWIDTH)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (r_inflight),
    .wr_dat (fifo_dout),
    .rd_en  (w_xfer),
    .cnt    (w_cnt),
    .head   (w_head),
    .full   (w_unused_full),
    .empty  (w_empty)
  );

  assign w_xfer      = m.tvalid & m.tready;
  assign w_len_eff   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  // Occupancy after this cycle settles: buffered + landing word - departing word.
  assign w_occ_nxt   = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_rd_en     = rst_n & ~fifo_empty & w_pop_allow & (w_occ_nxt < 3'd2);
  assign w_last_beat = (r_state == ST_XFER) & (r_beat == r_len_q - LEN_W'(1));
  assign w_more      = (w_occ_nxt != 3'd0) | w_rd_en;

`ifdef FIFO_RD_PKT_GATE_EN
  localparam int DEPTH = fifo_depth(AWIDTH);
  logic [LEN_W-1:0] r_pops, r_pop_len;
  logic             w_pop_done;
  logic [31:0]      w_need;
  logic             w_gate;

  assign w_pop_done  = (r_pops == r_pop_len);
  assign w_need      = (32'(w_len_eff) > 32'(DEPTH)) ? 32'(DEPTH) : 32'(w_len_eff);
  assign w_gate      = (32'(fifo_data_count) >= w_need);
  assign w_pop_allow = ~w_pop_done | w_gate;
  // Words still outstanding after a last beat belong to the prefetched packet.
  assign w_next_len  = (w_occ_nxt != 3'd0) ? r_pop_len : w_len_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pops    <= '0;
      r_pop_len <= '0;
    end else if (w_rd_en) begin
      if (w_pop_done) begin
        r_pops    <= LEN_W'(1);
        r_pop_len <= w_len_eff;
      end else begin
        r_pops    <= r_pops + LEN_W'(1);
      end
    end
  end
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^fifo_data_count;
  assign w_pop_allow  = 1'b1;
  assign w_next_len   = w_len_eff;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_len_nxt   = r_len_q;
    w_pkt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_en) begin
          w_state_nxt = ST_XFER;
          w_len_nxt   = w_len_eff;
        end
      end
      ST_XFER: begin
        if (w_xfer) begin
          if (w_last_beat) begin
            w_beat_nxt = '0;
            w_pkt_inc  = 1'b1;
            if (w_more) w_len_nxt   = w_next_len;
            else        w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt = r_beat + LEN_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len_q     <= LEN_W'(1);
      r_beat      <= '0;
      r_pkt_count <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len_q     <= w_len_nxt;
      r_beat      <= w_beat_nxt;
      r_inflight  <= w_rd_en;
      if (w_pkt_inc) r_pkt_count <= r_pkt_count + CNT_W'(1);
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m.tvalid   = ~w_empty;
  assign m.tdata    = w_head;
  assign m.tlast    = ~w_empty & w_last_beat;
  assign pkt_count  = r_pkt_count;
  assign busy       = (r_state == ST_XFER) | ~w_empty | r_inflight;
endmodule

// File: tb/tb_fifo_rd_axis_packetizer.sv
// Bench for fifo_rd_axis_packetizer: behavioural FIFO with 1-cycle read latency, scoreboard queue and negedge monitor.
module tb_fifo_rd_axis_packetizer;
  import fifo_pkg::*;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic [AW:0]   fifo_data_count;
  logic [LW-1:0] pkt_len;
  logic [CW-1:0] pkt_count;
  logic          busy;

  always #5 clk = ~clk;

  fifo_rd_axis_packetizer_if #(.DWIDTH(DW)) axis ();

  fifo_rd_axis_packetizer #(.DWIDTH(DW), .AWIDTH(AW), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .fifo_data_count (fifo_data_count),
    .pkt_len         (pkt_len),
    .m               (axis),
    .pkt_count       (pkt_count),
    .busy            (busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic [DW-1:0] fq [$];
  int            fcount = 0;
  logic          rd_s = 1'b0;
  exp_t          exp_q [$];
  int            n_chk = 0, n_pass = 0;
  int            cyc = 0, n_xfer = 0;
  int            rel_cyc = 0, lat = -1, want_lat = 0;
  int            b2b_on = 0, b2b_first = 1, last_cyc = 0, gap_err = 0;
  int            ovf = 0, exp_pkts = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  assign fifo_empty      = (fcount == 0);
  assign fifo_data_count = fcount[AW:0];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  // Behavioural FIFO: word popped at edge t is on fifo_dout after t.
  always @(negedge clk) rd_s <= fifo_rd_en;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_s && fq.size() > 0) begin
      fifo_dout <= fq.pop_front();
      fcount    <= fcount - 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (u_ovf_cond()) ovf++;
      if (prev_stall) chk("stall_hold", {31'd0, axis.tvalid, axis.tdata}, {31'd0, 1'b1, prev_dat});
      prev_stall = axis.tvalid && !axis.tready;
      prev_dat   = axis.tdata;
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard", axis.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(axis.tdata), 64'(e.d));
          chk("tlast", 64'(axis.tlast), 64'(e.l));
        end
        n_xfer++;
        if (want_lat != 0) begin
          lat = cyc - rel_cyc;
          want_lat = 0;
        end
        if (b2b_on != 0) begin
          if (b2b_first == 0 && cyc != last_cyc + 1) gap_err++;
          b2b_first = 0;
          last_cyc  = cyc;
        end
      end
    end
  end

  function automatic logic u_ovf_cond();
    return (dut.u_buf.cnt == 2'd2) && dut.r_inflight && !(axis.tvalid && axis.tready);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w, input logic last);
    fq.push_back(w);
    fcount = fcount + 1;
    exp_q.push_back('{d: w, l: last});
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick(1);
      k++;
    end
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int base;
    int early;
    rst_n       = 1'b0;
    axis.tready = 1'b1;
    pkt_len     = 16'd4;
    tick(3);
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_tlast", 64'(axis.tlast), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // 8 words, len 4, ready high: back-to-back beats, tlast on 3 and 7.
    for (int i = 0; i < 8; i++) push(DW'(i), (i % 4) == 3);
    tick(1);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    b2b_on = 1; b2b_first = 1; gap_err = 0;
    want_lat = 1;
    rel_cyc  = cyc;
    rst_n    = 1'b1;
    drain("t1", 100);
    exp_pkts += 2;
    b2b_on = 0;
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_b2b_gaps", 64'(gap_err), 64'd0);
    chk("t1_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Ready pattern 1,0,0,1 over 20 words.
    ovf = 0;
    for (int i = 0; i < 20; i++) push(DW'(100 + i), (i % 4) == 3);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      axis.tready = ((k % 4) == 0) || ((k % 4) == 3);
      tick(1);
    end
    axis.tready = 1'b1;
    drain("t2", 100);
    exp_pkts += 5;
    chk("t2_overflow", 64'(ovf), 64'd0);
    chk("t2_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Zero length reads as one beat.
    pkt_len = 16'd0;
    for (int i = 0; i < 3; i++) push(DW'(200 + i), 1'b1);
    drain("t3", 100);
    exp_pkts += 3;
    chk("t3_pkt_count", 64'(pkt_count), 64'(exp_pkts));

`ifdef FIFO_RD_PKT_GATE_EN
    // Trickle-fed len 5: no pop until 5 words sit in the FIFO, then a solid burst.
    pkt_len = 16'd5;
    early = 0;
    b2b_on = 1; b2b_first = 1; gap_err = 0;
    for (int i = 0; i < 5; i++) begin
      push(DW'(300 + i), i == 4);
      if (i < 4) begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          if (fifo_rd_en) early++;
          tick(1);
        end
      end
    end
    drain("t4", 100);
    exp_pkts += 1;
    b2b_on = 0;
    chk("t4_early_pop", 64'(early), 64'd0);
    chk("t4_b2b_gaps", 64'(gap_err), 64'd0);
    chk("t4_pkt_count", 64'(pkt_count), 64'(exp_pkts));
`else
    early = 0;
`endif

    // Reset mid-packet with beat 2 and a full buffer.
    pkt_len = 16'd4;
    axis.tready = 1'b1;
    base = n_xfer;
    for (int i = 0; i < 6; i++) push(DW'(400 + i), (i % 4) == 3);
    for (int k = 0; k < 50 && n_xfer < base + 2; k++) tick(1);
    axis.tready = 1'b0;
    chk("t5_beats_before", 64'(n_xfer - base), 64'd2);
    tick(4);
    chk("t5_buf_cnt", 64'(dut.u_buf.cnt), 64'd2);
    chk("t5_beat", 64'(dut.r_beat), 64'd2);
    rst_n = 1'b0;
    fq.delete();
    fcount = 0;
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
    chk("t5_tvalid", 64'(axis.tvalid), 64'd0);
    chk("t5_tlast", 64'(axis.tlast), 64'd0);
    chk("t5_pkt_count", 64'(pkt_count), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    exp_pkts = 0;
    axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(500 + i), i == 3);
    drain("t5", 100);
    exp_pkts += 1;
    chk("t5_restart_pkts", 64'(pkt_count), 64'(exp_pkts));

    // Length change during beat 1 applies only to the next packet.
    pkt_len = 16'd4;
    base = n_xfer;
    for (int i = 0; i < 6; i++) push(DW'(600 + i), (i == 3) || (i == 5));
    for (int k = 0; k < 50 && n_xfer < base + 1; k++) tick(1);
    pkt_len = 16'd2;
    drain("t6", 100);
    exp_pkts += 2;
    chk("t6_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/fifo_rd_axis_packetizer.md
Name: fifo_rd_axis_packetizer

Overview:
Read-side consumer of the async BRAM FIFO. It sits in the FIFO read clock domain and drives the FIFO read port. It absorbs the one-cycle BRAM read latency with a 2-entry output buffer and presents the data as an AXI-Stream master. The stream is framed into packets of runtime-programmable length, with m_tlast on the final beat of each packet, and the block sustains one word per cycle.

Parameters:
DWIDTH, 32, data width; matches the FIFO data width.
AWIDTH, 10, FIFO address width; the occupancy input is AWIDTH+1 bits.
LEN_W, 16, width of the packet-length input and the beat counter.
CNT_W, 32, width of the sent-packet counter.

Ports:
clk  in  1  single clock; the FIFO read clock.
rst_n  in  1  reset; synchronous, active-low.
fifo_rd_en  out  1  pop request to the FIFO read port.
fifo_dout  in  DWIDTH  FIFO read data; the word popped in cycle t is valid in cycle t+1.
fifo_empty  in  1  FIFO read-side empty flag.
fifo_data_count  in  AWIDTH+1  FIFO read-side occupancy; updates the cycle after a pop.
pkt_len  in  LEN_W  beats per packet; sampled at packet start.
m_tdata  out  DWIDTH  stream data.
m_tvalid  out  1  stream valid.
m_tready  in  1  stream ready.
m_tlast  out  1  last beat of a packet.
pkt_count  out  CNT_W  number of completed packets; wraps modulo 2^CNT_W.
busy  out  1  high while a packet is open or the buffer/in-flight state is non-empty.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs are 0, the buffer is emptied, inflight=0, beat=0, FSM goes to IDLE. A reset mid-packet discards buffered and in-flight words; the FIFO read side is reset by its own domain reset.
- Buffer: 2-entry FIFO (cnt 0..2). inflight is set in the cycle after fifo_rd_en=1; that cycle's fifo_dout is written into the buffer.
- Pop rule:
  - fifo_rd_en = ~fifo_empty & pop_allow & ((cnt + inflight − xfer) < 2), where xfer = m_tvalid & m_tready.
  - The buffer must never overflow; the bench asserts this.
  - Outputs are combinational from the buffer head, so there are no bubbles at steady state.
- Stream: m_tvalid = (cnt != 0); m_tdata = head entry. Once asserted, m_tvalid and m_tdata are held stable until xfer (AXI rule).
- Latency: with the FIFO non-empty and m_tready=1, the first beat appears 2 cycles after the first pop-eligible cycle.
- FSM states IDLE and XFER:
  - IDLE → XFER on the first pop; len_q is latched at that point.
  - In XFER, beat increments on each xfer. m_tlast = (beat == len_q−1).
  - On the last xfer: beat←0, pkt_count+1. The FSM goes to XFER if more data is available that cycle, else to IDLE.
- pkt_len: a value of 0 is treated as 1. Changes to pkt_len take effect only at the next packet start.
- Simultaneous write and read of the buffer in the same cycle: cnt is unchanged and order is preserved.
- m_tready low for any duration: pops stop once cnt + inflight reaches 2; no data is lost.
- Without the optional feature, pop_allow = 1.

Optional Feature:
FIFO_RD_PKT_GATE_EN.
- Defined:
  - Packet-start gating: IDLE → XFER only when fifo_data_count ≥ min(len, 2^AWIDTH), where len is pkt_len with 0 read as 1.
  - A pop counter limits pops to len_q per packet; pop_allow goes low once it is reached.
  - The gate is re-evaluated for the next packet as soon as all pops for the current packet have been issued, so the next packet can prefetch during the tail of the current one.
  - The result is whole-packet bursts with no mid-packet underrun stalls for packets up to the FIFO depth.
- Undefined: pop_allow = 1 and the pop counter/compare logic is absent. Packets can stall mid-way while the FIFO is empty.

Decomposition:
- Shared package fifo_pkg: the FIFO depth constant (2^AWIDTH), the FSM state encoding localparams (IDLE=0, XFER=1), and the default DWIDTH/AWIDTH.
- Sub-module skid_buf_2 is natural: the 2-entry buffer with write strobe, pop strobe, cnt, head data, and full/empty outputs. The top level holds the FSM, pop logic and counters.

Test Plan:
- Reset, then FIFO preloaded with 8 words 0..7, pkt_len=4, m_tready=1 → 8 beats on consecutive cycles, m_tlast on beats 3 and 7, pkt_count=2, busy drops.
- m_tready toggles 1,0,0,1 repeatedly with 20 words queued → data order preserved, no more than 2 words held in cnt+inflight, m_tdata stable while stalled.
- pkt_len=0 with 3 words → 3 single-beat packets, m_tlast on every beat, pkt_count=3.
- FIFO_RD_PKT_GATE_EN, pkt_len=5, words written 1 per 4 cycles → no fifo_rd_en until fifo_data_count=5, then 5 back-to-back beats with m_tlast on the fifth.
- rst_n low for 1 cycle mid-packet (beat=2, cnt=2) → outputs 0 the next cycle, pkt_count=0, and the next packet restarts at beat 0.
- pkt_len changed from 4 to 2 during beat 1 → the current packet ends at beat 3 and the following packet uses length 2.
